mult_share_arbiter: RTL and testbench

//  Shares one pipelined Multiplier32x32 between NUM_REQ requesters.
//  - Round-robin arbitration, at most one operand pair issued per cycle.
//  - Tags each issue with its requester ID and carries the tag alongside the multiplier pipeline.
//  - Returns each 64-bit product with its ID and a per-requester valid pulse.
//  - Sits between client blocks and the multiplier's A/B/Product ports.

---
 rtl/mult_share_arbiter.sv | 131 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one free-running pipelined multiplier between
// NUM_REQ requesters, tagging each issue so the product returns to its owner.
module mult_share_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = 32,
  parameter  int MULT_LATENCY = 2,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [2*DATA_W-1:0]       mul_product,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [2*DATA_W-1:0]       rsp_product,
  output logic                      busy
);

  logic [ID_W-1:0]     r_rr_ptr;
  logic [DATA_W-1:0]   r_mul_a;
  logic [DATA_W-1:0]   r_mul_b;
  logic [MULT_LATENCY:0] r_tag_vld;
  logic [ID_W-1:0]     r_tag_id [MULT_LATENCY+1];
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [2*DATA_W-1:0] r_rsp_product;

  logic                w_en;
  logic                w_hit;
  logic                w_found;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_gnt_id;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [NUM_REQ-1:0]  w_rsp_onehot;

  assign w_en = arb_en & rst_n;

  // Round-robin scan: first pass covers indices at/above rr_ptr, second pass wraps below it.
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    w_hit    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_hit      = w_en & ~w_found & req_valid[i] & (ID_W'(i) >= r_rr_ptr);
      w_grant[i] = w_grant[i] | w_hit;
      w_gnt_id   = w_hit ? ID_W'(i) : w_gnt_id;
      w_found    = w_found | w_hit;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_hit      = w_en & ~w_found & req_valid[i] & (ID_W'(i) < r_rr_ptr);
      w_grant[i] = w_grant[i] | w_hit;
      w_gnt_id   = w_hit ? ID_W'(i) : w_gnt_id;
      w_found    = w_found | w_hit;
    end
  end

  // One-hot AND-OR operand mux for the granted requester.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_a = w_sel_a | (req_a[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
      w_sel_b = w_sel_b | (req_b[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
    end
  end

  assign w_rsp_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_tag_id[MULT_LATENCY];

  // Pointer, issue registers and tag pipe; the tag pipe mirrors the multiplier depth plus the issue register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_tag_vld <= '0;
      for (int k = 0; k <= MULT_LATENCY; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      if (w_found) begin
        r_rr_ptr <= (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);
        r_mul_a  <= w_sel_a;
        r_mul_b  <= w_sel_b;
      end else begin
        r_rr_ptr <= r_rr_ptr;
        r_mul_a  <= r_mul_a;
        r_mul_b  <= r_mul_b;
      end
      r_tag_vld[0] <= w_found;
      r_tag_id[0]  <= w_gnt_id;
      for (int k = 1; k <= MULT_LATENCY; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
    end
  end

  // Response capture when the last tag stage lines up with the multiplier output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid   <= '0;
      r_rsp_id      <= '0;
      r_rsp_product <= '0;
    end else if (r_tag_vld[MULT_LATENCY]) begin
      r_rsp_valid   <= w_rsp_onehot;
      r_rsp_id      <= r_tag_id[MULT_LATENCY];
      r_rsp_product <= mul_product;
    end else begin
      r_rsp_valid   <= '0;
      r_rsp_id      <= r_rsp_id;
      r_rsp_product <= r_rsp_product;
    end
  end

  assign req_ready   = w_grant;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_product = r_rsp_product;
  assign busy        = |r_tag_vld;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter: a queue-based reference model predicts grants,
// issued operands, response timing/ownership/product and busy every cycle.
module tb_mult_share_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int NCYC  = 2500;

  logic            clk;
  logic            rst_n;
  logic            arb_en;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [DW-1:0]   mul_a;
  logic [DW-1:0]   mul_b;
  logic [2*DW-1:0] mul_product;
  logic [NREQ-1:0] rsp_valid;
  logic [1:0]      rsp_id;
  logic [2*DW-1:0] rsp_product;
  logic            busy;

  mult_share_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .MULT_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running two-stage multiplier standing in for the shared Multiplier32x32.
  logic [2*DW-1:0] p1, p2;
  always_ff @(posedge clk) begin
    p1 <= {32'd0, mul_a} * {32'd0, mul_b};
    p2 <= p1;
  end
  assign mul_product = p2;

  typedef struct {
    int          cyc;
    int          id;
    logic [63:0] prod;
  } rsp_t;

  rsp_t        pend[$];
  int          m_rr;
  logic [63:0] m_prod;
  int          m_id;
  logic [31:0] m_a, m_b;
  bit          synced;
  int          n_chk;
  int          n_fail;

  task automatic chk_eq(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (rr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive(input int c);
    logic [31:0] la [4];
    logic [31:0] lb [4];
    la[0] = 32'd3; la[1] = 32'd0; la[2] = 32'd1;          la[3] = $urandom;
    lb[0] = 32'd7; lb[1] = 32'd0; lb[2] = 32'hFFFF_FFFF;  lb[3] = $urandom;
    rst_n  = 1'b1;
    arb_en = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW] = $urandom;
      req_b[i*DW +: DW] = $urandom;
    end
    if (c < 3) begin
      rst_n     = 1'b0;
      req_valid = 4'b0000;
    end else if (c < 20) begin
      req_valid = 4'b0001;
      req_a[31:0] = 32'hFFFF_FFFF;
      req_b[31:0] = 32'hFFFF_FFFF;
    end else if (c < 50) begin
      req_valid = 4'b1111;
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*DW +: DW] = i + 1;
        req_b[i*DW +: DW] = 32'd10;
      end
    end else if (c < 58) begin
      req_valid = 4'b1111;
      arb_en    = 1'b0;
    end else if (c < 90) begin
      req_valid = 4'b0100;
      req_a[2*DW +: DW] = la[c % 4];
      req_b[2*DW +: DW] = lb[c % 4];
    end else if (c < 110) begin
      req_valid = ($urandom_range(0, 1) != 0) ? 4'b1010 : 4'b1000;
    end else begin
      req_valid = 4'($urandom);
      arb_en    = ($urandom_range(0, 9) != 0);
      rst_n     = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NREQ; i++) begin
          req_a[i*DW +: DW] = 32'hFFFF_FFFF;
        end
      end
    end
  endtask

  task automatic check_and_step(input int c);
    int          g;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_v;
    bit          exp_busy;
    logic [31:0] ga, gb;
    g = (rst_n && arb_en) ? pick(req_valid, m_rr) : -1;
    exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk_eq("req_ready", c, 64'(req_ready), 64'(exp_ready));
    if (synced) begin
      exp_v = 4'b0000;
      if (pend.size() > 0 && pend[0].cyc == c) begin
        exp_v  = 4'b0001 << pend[0].id;
        m_prod = pend[0].prod;
        m_id   = pend[0].id;
        void'(pend.pop_front());
      end
      exp_busy = 1'b0;
      foreach (pend[j]) begin
        if (pend[j].cyc <= c + LAT + 1) exp_busy = 1'b1;
      end
      chk_eq("rsp_valid", c, 64'(rsp_valid), 64'(exp_v));
      chk_eq("rsp_id", c, 64'(rsp_id), 64'(m_id));
      chk_eq("rsp_product", c, rsp_product, m_prod);
      chk_eq("mul_a", c, 64'(mul_a), 64'(m_a));
      chk_eq("mul_b", c, 64'(mul_b), 64'(m_b));
      chk_eq("busy", c, 64'(busy), 64'(exp_busy));
    end
    if (!rst_n) begin
      m_rr   = 0;
      pend.delete();
      m_prod = 64'd0;
      m_id   = 0;
      m_a    = 32'd0;
      m_b    = 32'd0;
      synced = 1'b1;
    end else if (g >= 0) begin
      ga = req_a[g*DW +: DW];
      gb = req_b[g*DW +: DW];
      pend.push_back('{cyc: c + LAT + 2, id: g, prod: {32'd0, ga} * {32'd0, gb}});
      m_rr = (g + 1) % NREQ;
      m_a  = ga;
      m_b  = gb;
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    synced    = 1'b0;
    m_rr      = 0;
    m_prod    = 64'd0;
    m_id      = 0;
    m_a       = 32'd0;
    m_b       = 32'd0;
    rst_n     = 1'b0;
    arb_en    = 1'b0;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      @(negedge clk);
      check_and_step(c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
